// File: rtl/rect_raster_pkg.sv
// rtl/rect_raster_pkg.sv - shared state, descriptor type and clipping helper for the raster engine
package rect_raster_pkg;

    localparam int RECT_XW = 10;
    localparam int RECT_DW = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        NEXT_RECT = 3'd2,
        DRAW      = 3'd3,
        FINISH    = 3'd4
    } state_e;

    typedef struct packed {
        logic               en;
        logic [RECT_XW-1:0] x;
        logic [RECT_XW-1:0] y;
        logic [RECT_XW-1:0] w;
        logic [RECT_XW-1:0] h;
        logic [RECT_DW-1:0] color;
    } rect_t;

    // One extra bit keeps start+size from wrapping before the screen-edge clamp.
    function automatic logic [RECT_XW:0] clip_end(input logic [RECT_XW-1:0] start,
                                                  input logic [RECT_XW-1:0] size,
                                                  input logic [RECT_XW:0]   limit);
        logic [RECT_XW:0] sum;
        sum = {1'b0, start} + {1'b0, size};
        return (sum < limit) ? sum : limit;
    endfunction

endpackage

// File: rtl/rect_raster_engine_raster_scan.sv
// rtl/rect_raster_engine_raster_scan.sv - 2-D raster counter over [x0,x_end) x [y0,y_end)
module raster_scan #(
    parameter int XW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [XW-1:0] x0_i,
    input  logic [XW-1:0] y0_i,
    input  logic [XW:0]   x_end_i,
    input  logic [XW:0]   y_end_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [XW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, y_q, x0_q;
    logic [XW:0]   xe_q, ye_q;
    logic [XW:0]   x_inc, y_inc;
    logic          row_end;

    assign x_inc   = {1'b0, x_q} + (XW+1)'(1);
    assign y_inc   = {1'b0, y_q} + (XW+1)'(1);
    assign row_end = (x_inc == xe_q);
    assign last_o  = row_end && (y_inc == ye_q);
    assign x_o     = x_q;
    assign y_o     = y_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q  <= '0;
            y_q  <= '0;
            x0_q <= '0;
            xe_q <= '0;
            ye_q <= '0;
        end else if (load_i) begin
            x_q  <= x0_i;
            y_q  <= y0_i;
            x0_q <= x0_i;
            xe_q <= x_end_i;
            ye_q <= y_end_i;
        end else if (advance_i) begin
            if (row_end) begin
                x_q <= x0_q;
                y_q <= y_inc[XW-1:0];
            end else begin
                x_q <= x_inc[XW-1:0];
            end
        end
    end

endmodule

// File: rtl/rect_raster_engine.sv
// rtl/rect_raster_engine.sv - clears the back buffer then paints up to NUM_RECT clipped rectangles
module rect_raster_engine
    import rect_raster_pkg::*;
#(
    parameter int            W        = 320,
    parameter int            H        = 240,
    parameter int            XW       = RECT_XW,
    parameter int            DW       = RECT_DW,
    parameter int            NUM_RECT = 8,
    parameter logic [DW-1:0] BG_COLOR = '0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   frame_start,
    input  logic [NUM_RECT-1:0]    rect_en,
    input  logic [NUM_RECT*XW-1:0] rect_x,
    input  logic [NUM_RECT*XW-1:0] rect_y,
    input  logic [NUM_RECT*XW-1:0] rect_w,
    input  logic [NUM_RECT*XW-1:0] rect_h,
    input  logic [NUM_RECT*DW-1:0] rect_color,
    input  logic                   wr_ready,
    output logic [XW-1:0]          draw_x,
    output logic [XW-1:0]          draw_y,
    output logic [DW-1:0]          draw_color,
    output logic                   wr_en,
    output logic                   busy,
    output logic                   swap_req,
    output logic [7:0]             overrun_cnt
);

    localparam logic [XW:0] W_L = (XW+1)'(W);
    localparam logic [XW:0] H_L = (XW+1)'(H);

    state_e        state_q, state_d;
    rect_t         rects_q [NUM_RECT];
    rect_t         cur;
    logic [4:0]    idx_q, idx_d;
    logic [DW-1:0] color_q, color_d;
    logic [7:0]    overrun_q;

    logic          writing, hs, drawable, last_slot;
    logic          scan_load, scan_last;
    logic [XW-1:0] scan_x0, scan_y0, scan_x, scan_y;
    logic [XW:0]   scan_xe, scan_ye;

    // Descriptor of the slot currently under evaluation; slot index may run one past the end.
    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_RECT; i++) begin
            if (idx_q == 5'(i)) cur = rects_q[i];
        end
    end

    assign drawable  = cur.en && (cur.w != '0) && (cur.h != '0)
                       && ({1'b0, cur.x} < W_L) && ({1'b0, cur.y} < H_L);
    assign last_slot = (idx_q == 5'(NUM_RECT - 1));
    assign writing   = (state_q == CLEAR) || (state_q == DRAW);
    assign hs        = writing && wr_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        color_d   = color_q;
        scan_load = 1'b0;
        scan_x0   = '0;
        scan_y0   = '0;
        scan_xe   = W_L;
        scan_ye   = H_L;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = CLEAR;
                    scan_load = 1'b1;
                end
            end
            CLEAR: begin
                if (hs && scan_last) begin
                    state_d = NEXT_RECT;
                    idx_d   = '0;
                end
            end
            NEXT_RECT: begin
                if (idx_q >= 5'(NUM_RECT)) begin
                    state_d = FINISH;
                end else if (drawable) begin
                    scan_load = 1'b1;
                    scan_x0   = cur.x;
                    scan_y0   = cur.y;
                    scan_xe   = clip_end(cur.x, cur.w, W_L);
                    scan_ye   = clip_end(cur.y, cur.h, H_L);
                    color_d   = cur.color;
                    state_d   = DRAW;
                end else if (last_slot) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            DRAW: begin
                if (hs && scan_last) begin
                    idx_d   = idx_q + 5'd1;
                    state_d = NEXT_RECT;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            color_q   <= '0;
            overrun_q <= '0;
            for (int i = 0; i < NUM_RECT; i++) rects_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            color_q <= color_d;
            if (frame_start && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
            if ((state_q == IDLE) && frame_start) begin
                for (int i = 0; i < NUM_RECT; i++) begin
                    rects_q[i] <= '{en:    rect_en[i],
                                    x:     rect_x[i*XW +: XW],
                                    y:     rect_y[i*XW +: XW],
                                    w:     rect_w[i*XW +: XW],
                                    h:     rect_h[i*XW +: XW],
                                    color: rect_color[i*DW +: DW]};
                end
            end
        end
    end

    raster_scan #(.XW(XW)) u_scan (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .load_i    (scan_load),
        .x0_i      (scan_x0),
        .y0_i      (scan_y0),
        .x_end_i   (scan_xe),
        .y_end_i   (scan_ye),
        .advance_i (hs),
        .x_o       (scan_x),
        .y_o       (scan_y),
        .last_o    (scan_last)
    );

    assign wr_en       = writing;
    assign draw_x      = writing ? scan_x : '0;
    assign draw_y      = writing ? scan_y : '0;
    assign draw_color  = (state_q == CLEAR) ? BG_COLOR : ((state_q == DRAW) ? color_q : '0);
    assign busy        = (state_q != IDLE);
    assign swap_req    = (state_q == FINISH);
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_rect_raster_engine.sv
// tb/tb_rect_raster_engine.sv - randomized self-checking bench for rect_raster_engine
module tb_rect_raster_engine;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int XW = 10;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam logic [DW-1:0] BG = 8'h3C;

    logic CLK = 1'b0;
    logic RESET, frame_start, wr_ready;
    logic [NR-1:0]    rect_en;
    logic [NR*XW-1:0] rect_x, rect_y, rect_w, rect_h;
    logic [NR*DW-1:0] rect_color;
    logic [XW-1:0]    draw_x, draw_y;
    logic [DW-1:0]    draw_color;
    logic             wr_en, busy, swap_req;
    logic [7:0]       overrun_cnt;

    int checks = 0;
    int errors = 0;

    int s_en[NR], s_x[NR], s_y[NR], s_w[NR], s_h[NR], s_c[NR];
    int m_en[NR], m_x[NR], m_y[NR], m_w[NR], m_h[NR], m_c[NR];
    int wq_x[$], wq_y[$], wq_c[$];
    int ex_x[$], ex_y[$], ex_c[$];
    int img[H][W];
    int exp_img[H][W];
    int swap_count, swap_cycle, stall_viol, busy_after, timed_out, first_bad;

    always #10 CLK = ~CLK;

    rect_raster_engine #(
        .W(W), .H(H), .XW(XW), .DW(DW), .NUM_RECT(NR), .BG_COLOR(BG)
    ) dut (
        .CLK(CLK), .RESET(RESET), .frame_start(frame_start),
        .rect_en(rect_en), .rect_x(rect_x), .rect_y(rect_y),
        .rect_w(rect_w), .rect_h(rect_h), .rect_color(rect_color),
        .wr_ready(wr_ready), .draw_x(draw_x), .draw_y(draw_y),
        .draw_color(draw_color), .wr_en(wr_en), .busy(busy),
        .swap_req(swap_req), .overrun_cnt(overrun_cnt)
    );

    task automatic apply_inputs();
        for (int i = 0; i < NR; i++) begin
            rect_en[i]              = (s_en[i] != 0);
            rect_x[i*XW +: XW]      = XW'(s_x[i]);
            rect_y[i*XW +: XW]      = XW'(s_y[i]);
            rect_w[i*XW +: XW]      = XW'(s_w[i]);
            rect_h[i*XW +: XW]      = XW'(s_h[i]);
            rect_color[i*DW +: DW]  = DW'(s_c[i]);
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < NR; i++) begin
            s_en[i] = 0; s_x[i] = 0; s_y[i] = 0; s_w[i] = 0; s_h[i] = 0; s_c[i] = 0;
        end
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int w, input int h, input int c);
        s_en[i] = 1; s_x[i] = x; s_y[i] = y; s_w[i] = w; s_h[i] = h; s_c[i] = c;
    endtask

    task automatic randomize_slots();
        for (int i = 0; i < NR; i++) begin
            s_en[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            s_x[i]  = $urandom_range(0, 9);
            s_y[i]  = $urandom_range(0, 5);
            s_w[i]  = $urandom_range(0, 6);
            s_h[i]  = $urandom_range(0, 5);
            s_c[i]  = $urandom_range(0, 255);
        end
    endtask

    // Reference: background fill, then each visible rectangle painted in slot order.
    task automatic build_expected();
        ex_x.delete(); ex_y.delete(); ex_c.delete();
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                exp_img[yy][xx] = BG;
                ex_x.push_back(xx); ex_y.push_back(yy); ex_c.push_back(BG);
            end
        for (int i = 0; i < NR; i++) begin
            if (m_en[i] != 0 && m_w[i] > 0 && m_h[i] > 0 && m_x[i] < W && m_y[i] < H) begin
                for (int yy = m_y[i]; yy < m_y[i] + m_h[i] && yy < H; yy++)
                    for (int xx = m_x[i]; xx < m_x[i] + m_w[i] && xx < W; xx++) begin
                        exp_img[yy][xx] = m_c[i];
                        ex_x.push_back(xx); ex_y.push_back(yy); ex_c.push_back(m_c[i]);
                    end
            end
        end
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) img[yy][xx] = -1;
        for (int k = 0; k < wq_x.size(); k++)
            if (wq_x[k] < W && wq_y[k] < H) img[wq_y[k]][wq_x[k]] = wq_c[k];
    endtask

    function automatic int write_mismatches();
        int n = 0;
        first_bad = -1;
        if (wq_x.size() != ex_x.size()) n++;
        for (int k = 0; k < wq_x.size() && k < ex_x.size(); k++) begin
            if (wq_x[k] != ex_x[k] || wq_y[k] != ex_y[k] || wq_c[k] != ex_c[k]) begin
                if (first_bad < 0) first_bad = k;
                n++;
            end
        end
        return n;
    endfunction

    function automatic int image_mismatches();
        int n = 0;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                if (img[yy][xx] != exp_img[yy][xx]) n++;
        return n;
    endfunction

    task automatic run_frame(input int rnd_ready, input int n_extra);
        int cyc, done, prev_stall, px, py, pc;
        wq_x.delete(); wq_y.delete(); wq_c.delete();
        swap_count = 0; swap_cycle = -1; stall_viol = 0; busy_after = -1;
        @(negedge CLK);
        apply_inputs();
        for (int i = 0; i < NR; i++) begin
            m_en[i] = s_en[i]; m_x[i] = s_x[i]; m_y[i] = s_y[i];
            m_w[i] = s_w[i]; m_h[i] = s_h[i]; m_c[i] = s_c[i];
        end
        frame_start = 1'b1;
        wr_ready    = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
        randomize_slots();
        apply_inputs();
        cyc = 1; done = 0; prev_stall = 0; px = 0; py = 0; pc = 0;
        while (!done && cyc < 4000) begin
            frame_start = (n_extra > 0 && cyc % 5 == 0 && cyc / 5 <= n_extra);
            wr_ready    = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && (wr_en !== 1'b1 || int'(draw_x) != px || int'(draw_y) != py || int'(draw_color) != pc))
                stall_viol++;
            if (wr_en === 1'b1 && wr_ready) begin
                wq_x.push_back(int'(draw_x)); wq_y.push_back(int'(draw_y)); wq_c.push_back(int'(draw_color));
            end
            prev_stall = (wr_en === 1'b1 && !wr_ready);
            px = int'(draw_x); py = int'(draw_y); pc = int'(draw_color);
            if (swap_req === 1'b1) begin
                swap_count++;
                if (swap_cycle < 0) swap_cycle = cyc;
            end else if (swap_count > 0) begin
                done = 1;
                busy_after = int'(busy);
            end
            if (!done) begin
                @(negedge CLK);
                cyc++;
            end
        end
        frame_start = 1'b0;
        wr_ready    = 1'b1;
        timed_out   = !done;
        build_expected();
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; frame_start = 1'b1; wr_ready = 1'b1;
        randomize_slots(); apply_inputs();
        repeat (3) @(negedge CLK);
        RESET = 1'b0; frame_start = 1'b0;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (swap_req !== 1'b0) begin errors++; $display("FAIL reset_swap: got %b expected 0", swap_req); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt); end
        checks++; if (draw_x !== '0 || draw_y !== '0 || draw_color !== '0) begin
            errors++; $display("FAIL reset_draw: got x=%0d y=%0d c=%0d expected 0,0,0", draw_x, draw_y, draw_color);
        end
    endtask

    task automatic test_clear_only();
        int m;
        clear_slots();
        run_frame(0, 0);
        m = write_mismatches();
        checks++; if (timed_out != 0) begin errors++; $display("FAIL clear_timeout: got no swap expected swap"); end
        checks++; if (wq_x.size() != W * H) begin errors++; $display("FAIL clear_count: got %0d expected %0d", wq_x.size(), W * H); end
        checks++; if (m != 0) begin errors++; $display("FAIL clear_order: got %0d bad writes (first %0d) expected 0", m, first_bad); end
        checks++; if (swap_count != 1) begin errors++; $display("FAIL clear_swap_count: got %0d expected 1", swap_count); end
        checks++; if (swap_cycle != 34 + NR - 1) begin errors++; $display("FAIL clear_swap_cycle: got %0d expected %0d", swap_cycle, 34 + NR - 1); end
        checks++; if (busy_after != 0) begin errors++; $display("FAIL clear_busy_after: got %0d expected 0", busy_after); end
    endtask

    task automatic test_single_rect();
        int m;
        clear_slots();
        set_slot(0, 2, 1, 3, 2, 5);
        run_frame(0, 0);
        m = write_mismatches();
        checks++; if (wq_x.size() != W * H + 6) begin errors++; $display("FAIL single_count: got %0d expected %0d", wq_x.size(), W * H + 6); end
        checks++; if (m != 0) begin errors++; $display("FAIL single_writes: got %0d bad writes (first %0d) expected 0", m, first_bad); end
        checks++; if (image_mismatches() != 0) begin errors++; $display("FAIL single_image: got %0d bad pixels expected 0", image_mismatches()); end
    endtask

    task automatic test_clipping();
        int m;
        clear_slots();
        set_slot(0, 6, 3, 5, 4, 9);
        run_frame(0, 0);
        m = write_mismatches();
        checks++; if (wq_x.size() != W * H + 2) begin errors++; $display("FAIL clip_count: got %0d expected %0d", wq_x.size(), W * H + 2); end
        checks++; if (m != 0) begin errors++; $display("FAIL clip_writes: got %0d bad writes (first %0d) expected 0", m, first_bad); end
        clear_slots();
        set_slot(0, 8, 0, 3, 3, 9);
        run_frame(0, 0);
        checks++; if (wq_x.size() != W * H) begin errors++; $display("FAIL clip_offscreen_count: got %0d expected %0d", wq_x.size(), W * H); end
    endtask

    task automatic test_overlap();
        clear_slots();
        set_slot(0, 0, 0, 4, 4, 1);
        set_slot(1, 2, 2, 4, 4, 2);
        run_frame(0, 0);
        checks++; if (img[3][3] != 2) begin errors++; $display("FAIL overlap_3_3: got %0d expected 2", img[3][3]); end
        checks++; if (img[1][1] != 1) begin errors++; $display("FAIL overlap_1_1: got %0d expected 1", img[1][1]); end
        checks++; if (image_mismatches() != 0) begin errors++; $display("FAIL overlap_image: got %0d bad pixels expected 0", image_mismatches()); end
    endtask

    task automatic test_random_frames();
        int m;
        for (int f = 0; f < 6; f++) begin
            randomize_slots();
            run_frame(f % 2, 0);
            m = write_mismatches();
            checks++; if (timed_out != 0) begin errors++; $display("FAIL rand%0d_timeout: got no swap expected swap", f); end
            checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand%0d_stall: got %0d unstable stalls expected 0", f, stall_viol); end
            checks++; if (m != 0) begin errors++; $display("FAIL rand%0d_writes: got %0d bad writes (first %0d, n=%0d) expected 0 (n=%0d)", f, m, first_bad, wq_x.size(), ex_x.size()); end
            checks++; if (image_mismatches() != 0) begin errors++; $display("FAIL rand%0d_image: got %0d bad pixels expected 0", f, image_mismatches()); end
            checks++; if (swap_count != 1) begin errors++; $display("FAIL rand%0d_swap: got %0d expected 1", f, swap_count); end
        end
    endtask

    task automatic test_overrun();
        int m;
        clear_slots();
        set_slot(2, 1, 1, 2, 2, 77);
        run_frame(0, 3);
        m = write_mismatches();
        checks++; if (overrun_cnt !== 8'd3) begin errors++; $display("FAIL overrun_cnt: got %0d expected 3", overrun_cnt); end
        checks++; if (swap_count != 1) begin errors++; $display("FAIL overrun_swap: got %0d expected 1", swap_count); end
        checks++; if (m != 0) begin errors++; $display("FAIL overrun_writes: got %0d bad writes expected 0", m); end
    endtask

    task automatic test_saturation();
        pulse_reset();
        wr_ready = 1'b0;
        clear_slots(); apply_inputs();
        frame_start = 1'b1;
        repeat (301) @(negedge CLK);
        frame_start = 1'b0;
        @(negedge CLK);
        checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_overrun: got %0d expected 255", overrun_cnt); end
        checks++; if (wr_en !== 1'b1 || draw_x !== '0 || draw_y !== '0 || draw_color !== BG) begin
            errors++; $display("FAIL sat_stall_hold: got en=%b x=%0d y=%0d c=%0d expected 1,0,0,%0d", wr_en, draw_x, draw_y, draw_color, BG);
        end
        wr_ready = 1'b1;
        pulse_reset();
    endtask

    task automatic test_reset_mid_draw();
        int seen, cyc, bad;
        clear_slots();
        set_slot(0, 0, 0, 4, 4, 1);
        apply_inputs();
        @(negedge CLK);
        frame_start = 1'b1; wr_ready = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
        repeat (3) @(negedge CLK);
        frame_start = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 200) begin
            if (wr_en === 1'b1 && draw_color === 8'd1) seen++;
            if (seen < 2) begin @(negedge CLK); cyc++; end
        end
        checks++; if (seen < 2) begin errors++; $display("FAIL midreset_reach_draw: got %0d draw writes expected 2", seen); end
        checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL midreset_pre_overrun: got %0d expected 1", overrun_cnt); end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midreset_wr_en: got %b expected 0", wr_en); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL midreset_overrun: got %0d expected 0", overrun_cnt); end
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            if (swap_req !== 1'b0 || wr_en !== 1'b0) bad++;
            @(negedge CLK);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad); end
    endtask

    initial begin
        RESET = 1'b1; frame_start = 1'b0; wr_ready = 1'b1;
        clear_slots(); apply_inputs();
        test_reset();
        test_clear_only();
        test_single_rect();
        test_clipping();
        test_overlap();
        test_random_frames();
        test_overrun();
        test_saturation();
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
